// File: rtl/image_loader.sv
// image_loader: streams pixel bytes into image memory as Q8.8 words, one frame at a time
module image_loader #(
  parameter int NUM_PIXELS = 784,
  parameter bit INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_sof,
  input  logic        frame_ack,
  output logic        img_we,
  output logic [9:0]  img_addr,
  output logic [15:0] img_data,
  output logic        load_complete,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [9:0] LAST = 10'(NUM_PIXELS - 1);
  state_t state, state_nx;
  logic [9:0] cnt, cnt_nx, wr_addr;
  logic xfer, wr, last, err_set, err_clr;
  // handshake, write decode, pixel counter and next state
  always_comb begin
    s_ready = state != DONE;
    xfer = s_valid & s_ready;
    wr = xfer & (state == LOAD | s_sof);
    wr_addr = s_sof ? '0 : cnt;
    last = wr_addr == LAST;
    cnt_nx = wr ? (last ? '0 : wr_addr + 10'd1) : cnt;
    err_set = xfer & (state == LOAD ? s_sof : !s_sof);
    err_clr = xfer & state == IDLE & s_sof;
    state_nx = wr ? (last ? DONE : LOAD) : (state == DONE && frame_ack) ? IDLE : state;
  end
  // state, counter and registered memory-write/status outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      img_we <= 1'b0;
      img_addr <= '0;
      img_data <= '0;
      load_complete <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      img_we <= wr;
      if (wr) begin
        img_addr <= wr_addr;
        img_data <= {8'h00, INVERT ? 8'hFF - s_data : s_data};
      end
      load_complete <= state == DONE && state_nx == DONE;
      frame_err <= err_set | (frame_err & !err_clr);
    end
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: directed frames checked every cycle against a per-pixel behavioural model
module tb_image_loader;
  localparam int N = 784;
  logic clk = 0, reset = 0, s_valid = 0, s_sof = 0, frame_ack = 0;
  logic [7:0] s_data = 0;
  logic rdy0, rdy1, we0, we1, lc0, lc1, err0, err1;
  logic [9:0] addr0, addr1;
  logic [15:0] d0, d1;
  int n_chk = 0, n_fail = 0, writes = 0;
  logic [15:0] last_d0 = 0, last_d1 = 0;
  logic [9:0] last_a = 0;
  int ph = 0, pos = 0, e_addr = 0;
  logic e_we = 0, e_lc = 0, e_err = 0;
  logic [7:0] e_byte = 0;

  always #5 clk = ~clk;

  image_loader #(.NUM_PIXELS(N), .INVERT(1'b0)) u0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
    .s_sof(s_sof), .frame_ack(frame_ack), .img_we(we0), .img_addr(addr0),
    .img_data(d0), .load_complete(lc0), .frame_err(err0));
  image_loader #(.NUM_PIXELS(N), .INVERT(1'b1)) u1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
    .s_sof(s_sof), .frame_ack(frame_ack), .img_we(we1), .img_addr(addr1),
    .img_data(d1), .load_complete(lc1), .frame_err(err1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: ph 0 = waiting for a frame, 1 = loading at pixel pos, 2 = frame resident
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; pos = 0; e_we = 0; e_addr = 0; e_byte = 0; e_lc = 0; e_err = 0;
    end else begin
      e_we = 0;
      e_lc = 0;
      if (ph == 2) begin
        e_lc = !frame_ack;
        if (frame_ack) ph = 0;
      end else if (s_valid) begin
        if (s_sof) e_err = ph == 1;
        else if (ph == 0) e_err = 1;
        if (s_sof || ph == 1) begin
          e_we = 1;
          e_addr = s_sof ? 0 : pos;
          e_byte = s_data;
          ph = e_addr == N - 1 ? 2 : 1;
          pos = ph == 2 ? 0 : e_addr + 1;
        end
      end
    end
    #1;
    chk("we", we0, e_we);
    chk("we_inv", we1, e_we);
    chk("ready", rdy0, ph != 2);
    chk("ready_inv", rdy1, ph != 2);
    chk("load_complete", lc0, e_lc);
    chk("load_complete_inv", lc1, e_lc);
    chk("frame_err", err0, e_err);
    chk("frame_err_inv", err1, e_err);
    if (e_we || !reset) begin
      chk("addr", addr0, 32'(e_addr));
      chk("addr_inv", addr1, 32'(e_addr));
      chk("data", d0, !reset ? 16'h0 : {8'h00, e_byte});
      chk("data_inv", d1, !reset ? 16'h0 : {8'h00, 8'hFF - e_byte});
    end
    if (we0) begin
      writes++;
      last_a = addr0;
      last_d0 = d0;
      last_d1 = d1;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic sof, input logic ack);
    s_valid = v; s_data = d; s_sof = sof; frame_ack = ack;
    @(negedge clk);
  endtask

  initial begin
    int k;
    #2;
    chk("rst_we", we0, 0);
    chk("rst_lc", lc0, 0);
    chk("rst_err", err0, 0);
    #10 reset = 1;
    #1;
    chk("post_rst_addr", addr0, 0);
    chk("post_rst_data", d1, 0);
    @(negedge clk);
    writes = 0;
    for (int i = 0; i < N; i++) drive(1, 8'(i), i == 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'hAA, 0, 0);
    chk("frame_writes", writes, 784);
    chk("frame_last_addr", last_a, 783);
    chk("frame_last_data", last_d0, 16'h000F);
    chk("frame_last_data_inv", last_d1, 16'h00F0);
    chk("frame_resident", lc0, 1);
    chk("frame_ready_low", rdy0, 0);
    drive(1, 8'hAA, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'hAA, 0, 0);
    chk("extras_dropped", writes, 784);
    chk("extras_err", err0, 1);
    chk("extras_lc_low", lc0, 0);
    writes = 0;
    for (int i = 0; i < 100; i++) drive(1, 8'(i), i == 0, i == 50);
    chk("sof_clears_err", err0, 0);
    for (int i = 0; i < N; i++) drive(1, 8'(i + 7), i == 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("restart_writes", writes, 884);
    chk("restart_err", err0, 1);
    chk("restart_last_addr", last_a, 783);
    chk("restart_resident", lc0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    writes = 0;
    k = 0;
    while (k < N) begin
      if ($urandom_range(0, 2) == 0) drive(0, 8'h10, 0, 0);
      else begin
        drive(1, 8'h10, k == 0, 0);
        k++;
      end
    end
    drive(0, 8'h10, 0, 0);
    drive(0, 8'h10, 0, 0);
    chk("gap_writes", writes, 784);
    chk("gap_data_inv", last_d1, 16'h00EF);
    chk("gap_data", last_d0, 16'h0010);
    chk("gap_err_cleared", err0, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) drive(1, 8'(i), i == 0, 0);
    #3 reset = 0;
    #1;
    chk("async_we", we0, 0);
    chk("async_addr", addr0, 0);
    chk("async_data", d0, 0);
    chk("async_data_inv", d1, 0);
    @(negedge clk);
    #2 reset = 1;
    @(negedge clk);
    writes = 0;
    drive(1, 8'h33, 0, 0);
    drive(0, 0, 0, 0);
    chk("post_rst_no_write", writes, 0);
    chk("post_rst_err", err0, 1);
    for (int i = 0; i < N - 1; i++) drive(1, 8'(i), i == 0, 0);
    drive(0, 0, 0, 0);
    chk("lc_not_early", lc0, 0);
    drive(1, 8'(N - 1), 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("post_rst_writes", writes, 784);
    chk("post_rst_resident", lc0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 784, pixels per frame (28x28).
REQ-002 Parameter INVERT, default 0; 1 = store 255-byte instead of byte.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  upstream pixel byte valid.
REQ-006 s_ready  output  1  loader can accept a byte this cycle.
REQ-007 s_data  input  8  unsigned pixel intensity.
REQ-008 s_sof  input  1  start-of-frame marker, qualified by s_valid; marks pixel 0.
REQ-009 frame_ack  input  1  one-cycle pulse from the network control: frame consumed, release buffer.
REQ-010 img_we  output  1  image memory write enable, one cycle per pixel.
REQ-011 img_addr  output  10  image memory write address, equal to pixel_no of the written pixel.
REQ-012 img_data  output  16  grayscale word, Q8.8 unsigned.
REQ-013 load_complete  output  1  level; full frame is resident in image memory.
REQ-014 frame_err  output  1  sticky framing-error flag.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD and DONE.
REQ-016 The handshake SHALL transfer a byte on any rising edge where s_valid=1 and s_ready=1.
REQ-017 s_ready SHALL be 1 in IDLE and LOAD and 0 in DONE.
REQ-018 Conversion: img_data SHALL be {8'h00, p}, where p=s_data (INVERT=0) or 8'hFF-s_data (INVERT=1).
REQ-019 Write latency: a byte accepted at edge N SHALL produce img_we=1, with its address and data, for the single cycle following edge N.
REQ-020 img_we SHALL be 0 in every cycle that follows an edge with no transfer.
REQ-021 IDLE, transfer with s_sof=1: write to address 0, go to LOAD, internal pixel counter=1.
REQ-022 IDLE, transfer with s_sof=0: byte dropped (no write), frame_err set, stay IDLE.
REQ-023 LOAD, transfer with s_sof=0: write to address = counter, then counter increments.
REQ-024 LOAD, transfer with s_sof=1 (premature restart): frame_err set, write to address 0, counter=1, stay LOAD.
REQ-025 LOAD, transfer writing address NUM_PIXELS-1: go to DONE; counter resets to 0.
REQ-026 load_complete SHALL rise in the cycle after the img_we pulse of address NUM_PIXELS-1, stay 1 throughout DONE, and be 0 otherwise.
REQ-027 DONE, frame_ack=1: go to IDLE next edge; load_complete falls in that cycle; no byte accepted on that edge.
REQ-028 frame_ack SHALL be ignored in IDLE and LOAD.
REQ-029 frame_err SHALL clear on the next accepted s_sof byte that starts a frame from IDLE; the same-edge set condition (REQ-024) takes priority over clear.
REQ-030 The counter SHALL never exceed NUM_PIXELS-1; img_addr SHALL never reach NUM_PIXELS.
REQ-031 Pauses (s_valid=0) of any length in LOAD SHALL NOT change state or counter.

Reset
REQ-032 Reset asserted: state=IDLE, counter=0, img_we=0, img_addr=0, img_data=0, load_complete=0, frame_err=0.
REQ-033 Reset applied mid-LOAD or in DONE SHALL abort the frame immediately; the partial frame is discarded and no write occurs until a new s_sof byte arrives.
REQ-034 Outputs SHALL be reset values from reset deassertion until the first rising clock edge.

Verification
REQ-035 Full frame: 784 back-to-back bytes 0..255 repeating, s_sof on the first -> 784 img_we pulses, addr 0..783, img_data[7:0]=addr mod 256; load_complete=1 the cycle after addr 783; s_ready=0.
REQ-036 Backpressure: 784 bytes then 5 more held valid -> extra bytes not accepted until frame_ack pulse, then IDLE; extras without s_sof dropped and frame_err=1.
REQ-037 Restart: s_sof at pixel 0, 100 bytes, s_sof again -> frame_err=1, next write at addr 0, frame completes 784 bytes after the second s_sof.
REQ-038 Gapped stream: random s_valid gaps, INVERT=1, s_data=8'h10 -> every img_data=16'h00EF, addresses contiguous, no write in gap cycles.
REQ-039 Reset mid-frame at pixel 400 -> all outputs zero asynchronously; subsequent s_sof frame writes from addr 0; load_complete only after 784 new bytes.
REQ-040 Late ack: frame_ack pulsed during LOAD -> no effect; frame completes normally.
